// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared states, op bit positions and shift-function codes for shift_sequencer
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int OP_DIR_BIT  = 0;
  localparam int OP_PORT_BIT = 1;

  localparam logic [1:0] FUN_A_RIGHT = 2'b00;
  localparam logic [1:0] FUN_A_LEFT  = 2'b01;
  localparam logic [1:0] FUN_B_RIGHT = 2'b10;
  localparam logic [1:0] FUN_B_LEFT  = 2'b11;

  // Shift unit function code is {port select, direction}.
  function automatic logic [1:0] op_to_fun(input logic [1:0] op);
    return {op[OP_PORT_BIT], op[OP_DIR_BIT]};
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request/result handshake bundle between command decoder and shift_sequencer
interface shift_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_data;
  logic [AMT_WIDTH-1:0]  req_amt;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_err;

  modport master (
    output req_valid, req_op, req_data, req_amt, res_ready,
    input  req_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_amt, res_ready,
    output req_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/shift_amount_counter.sv
// rtl/shift_amount_counter.sv - loadable down-counter of remaining shift steps, saturating at zero
module shift_amount_counter #(
  parameter int AMT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [AMT_WIDTH-1:0] i_load_val,
  input  logic                 i_dec,
  output logic [AMT_WIDTH-1:0] o_count,
  output logic                 o_zero
);

  localparam logic [AMT_WIDTH-1:0] AMT_ONE = AMT_WIDTH'(1);

  logic [AMT_WIDTH-1:0] r_count;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - AMT_ONE;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterates the 1-bit registered shift unit for multi-position shifts (option: SHIFT_SEQ_FASTPATH_EN)
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_seq_if.slave            bus,
  output logic                  busy,
  output logic                  sh_en,
  output logic [1:0]            sh_fun,
  output logic [DATA_WIDTH-1:0] sh_a,
  output logic [DATA_WIDTH-1:0] sh_b,
  input  logic [DATA_WIDTH-1:0] sh_out,
  input  logic                  sh_flag
);

  localparam logic [AMT_WIDTH-1:0] AMT_ONE = AMT_WIDTH'(1);

  seq_state_e            r_state;
  seq_state_e            w_next;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_work;
  logic                  r_err;
  logic                  w_load;
  logic                  w_dec;
  logic [AMT_WIDTH-1:0]  w_count;
  logic                  w_zero;
  logic                  w_fast;
  logic [1:0]            w_fun;
  logic                  w_drive_a;
  logic                  w_drive_b;

`ifdef SHIFT_SEQ_FASTPATH_EN
  localparam logic [AMT_WIDTH:0] DW_AMT = DATA_WIDTH[AMT_WIDTH:0];
  // Any amount of DATA_WIDTH or more shifts every bit out, so the answer is known up front.
  assign w_fast = ({1'b0, bus.req_amt} >= DW_AMT);
`else
  assign w_fast = 1'b0;
`endif

  shift_amount_counter #(
    .AMT_WIDTH (AMT_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (bus.req_amt),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    sh_en         = 1'b0;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          w_load = 1'b1;
          w_next = ((bus.req_amt == '0) || w_fast) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // A zero count here would mean nothing left to do; never pulse the unit for it.
        sh_en  = !w_zero;
        w_next = w_zero ? DONE : WAIT;
      end
      WAIT: begin
        w_dec  = 1'b1;
        w_next = (w_count == AMT_ONE) ? DONE : ISSUE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Work register, latched op and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_work <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_op   <= bus.req_op;
            r_work <= w_fast ? '0 : bus.req_data;
            r_err  <= 1'b0;
          end
        end
        WAIT: begin
          r_work <= sh_out;
          if (!sh_flag) begin
            r_err <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_fun     = op_to_fun(r_op);
  assign w_drive_a = (w_fun == FUN_A_RIGHT) || (w_fun == FUN_A_LEFT);
  assign w_drive_b = (w_fun == FUN_B_RIGHT) || (w_fun == FUN_B_LEFT);

  // Operands and function are only presented during the enable pulse; otherwise both ports idle at 0.
  assign sh_fun = sh_en ? w_fun : 2'b00;
  assign sh_a   = (sh_en && w_drive_a) ? r_work : '0;
  assign sh_b   = (sh_en && w_drive_b) ? r_work : '0;

  assign busy         = (r_state != IDLE);
  assign bus.res_data = (r_state == DONE) ? r_work : '0;
  assign bus.res_err  = (r_state == DONE) ? r_err : 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with a behavioural shift unit
module tb_shift_sequencer;

  localparam int DW = 16;
  localparam int AW = 5;

`ifdef SHIFT_SEQ_FASTPATH_EN
  localparam int LAT20 = 1;
  localparam int LAT31 = 1;
`else
  localparam int LAT20 = 41;
  localparam int LAT31 = 63;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_seq_if #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) bus ();

  logic          busy;
  logic          sh_en;
  logic [1:0]    sh_fun;
  logic [DW-1:0] sh_a;
  logic [DW-1:0] sh_b;
  logic [DW-1:0] sh_out;
  logic          sh_flag;

  shift_sequencer #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .sh_en   (sh_en),
    .sh_fun  (sh_fun),
    .sh_a    (sh_a),
    .sh_b    (sh_b),
    .sh_out  (sh_out),
    .sh_flag (sh_flag)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] shifted(input logic [DW-1:0] d, input logic [1:0] op, input int n);
    if (n >= DW) return '0;
    return op[0] ? (d << n) : (d >> n);
  endfunction

  function automatic int latency(input int amt);
`ifdef SHIFT_SEQ_FASTPATH_EN
    if (amt >= DW) return 1;
`endif
    return (amt == 0) ? 1 : 2 * amt + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-step shift unit: registered result, flag normally 1, forced 0 on one chosen step.
  logic [DW-1:0] su_out  = '0;
  logic          su_flag = 1'b0;
  int            su_step = 0;
  int            force_step = 0;
  assign sh_out  = su_out;
  assign sh_flag = su_flag;

  always @(posedge clk) begin
    if (rst) begin
      su_out  <= '0;
      su_flag <= 1'b0;
      su_step <= 0;
    end else if (sh_en) begin
      su_step <= su_step + 1;
      su_flag <= ((su_step + 1) != force_step);
      case (sh_fun)
        2'b00:   su_out <= sh_a >> 1;
        2'b01:   su_out <= sh_a << 1;
        2'b10:   su_out <= sh_b >> 1;
        default: su_out <= sh_b << 1;
      endcase
    end else if (bus.req_valid && bus.req_ready) begin
      su_step <= 0;
    end
  end

  // Reference model of one outstanding request, compared every cycle.
  bit            pending = 1'b0;
  bit            prev_en = 1'b0;
  int            acc_cyc, exp_lat, exp_pulses, pulses;
  logic [DW-1:0] m_data, exp_data;
  logic [1:0]    m_op;
  bit            exp_err;

  always @(negedge clk) begin
    int n;
    if (rst) begin
      check("rst_req_ready", 32'(bus.req_ready), 32'(0));
      pending = 1'b0;
      prev_en = 1'b0;
    end else begin
      n = pending ? (cyc - acc_cyc) : 0;
      check("busy", 32'(busy), 32'(pending && n >= 1));
      check("req_ready", 32'(bus.req_ready), 32'(!(pending && n >= 1)));
      check("res_valid", 32'(bus.res_valid), 32'(pending && n >= exp_lat));
      if (bus.res_valid) begin
        check("res_data", 32'(bus.res_data), 32'(exp_data));
        check("res_err", 32'(bus.res_err), 32'(exp_err));
      end
      if (sh_en) begin
        check("sh_en_in_op", 32'(pending), 32'(1));
        check("sh_en_single", 32'(prev_en), 32'(0));
        check("sh_fun", 32'(sh_fun), 32'(m_op));
        if (m_op[1]) begin
          check("sh_b_operand", 32'(sh_b), 32'(shifted(m_data, m_op, pulses)));
          check("sh_a_unused", 32'(sh_a), 32'(0));
        end else begin
          check("sh_a_operand", 32'(sh_a), 32'(shifted(m_data, m_op, pulses)));
          check("sh_b_unused", 32'(sh_b), 32'(0));
        end
        pulses++;
      end else begin
        check("sh_ports_idle", {sh_a, sh_b}, 32'(0));
      end
      prev_en = sh_en;
      if (pending && bus.res_valid && bus.res_ready) begin
        check("sh_en_count", 32'(pulses), 32'(exp_pulses));
        pending = 1'b0;
      end
      if (!pending && bus.req_valid && bus.req_ready) begin
        pending    = 1'b1;
        acc_cyc    = cyc;
        pulses     = 0;
        m_op       = bus.req_op;
        m_data     = bus.req_data;
        exp_data   = shifted(bus.req_data, bus.req_op, int'(bus.req_amt));
        exp_lat    = latency(int'(bus.req_amt));
        exp_pulses = (exp_lat == 1) ? 0 : int'(bus.req_amt);
        exp_err    = (force_step >= 1) && (force_step <= exp_pulses);
      end
    end
  end

  task automatic run_req(input string name, input logic [1:0] op, input logic [DW-1:0] data,
                         input logic [AW-1:0] amt, input int hold, input int fstep,
                         input logic [DW-1:0] lit_data, input int lit_lat, input bit lit_err);
    int c0;
    int lat;
    bit got;
    force_step = fstep;
    check({name, "_model_data"}, 32'(shifted(data, op, int'(amt))), 32'(lit_data));
    check({name, "_model_lat"}, 32'(latency(int'(amt))), 32'(lit_lat));
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    bus.req_amt   = amt;
    got = 1'b0;
    c0  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        c0  = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_accepted"}, 32'(got), 32'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_data  = 16'hA5A5;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        got = 1'b1;
        lat = cyc - c0;
        break;
      end
    end
    check({name, "_valid_seen"}, 32'(got), 32'(1));
    check({name, "_latency"}, 32'(lat), 32'(lit_lat));
    check({name, "_data"}, 32'(bus.res_data), 32'(lit_data));
    check({name, "_err"}, 32'(bus.res_err), 32'(lit_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_amt   = '0;
      @(negedge clk);
    end
    if (hold > 0) begin
      check({name, "_held_valid"}, 32'(bus.res_valid), 32'(1));
      check({name, "_held_data"}, 32'(bus.res_data), 32'(lit_data));
      check({name, "_held_err"}, 32'(bus.res_err), 32'(lit_err));
      check({name, "_held_ready"}, 32'(bus.req_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check({name, "_handshake"}, 32'(bus.res_valid), 32'(1));
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check({name, "_released"}, 32'(bus.res_valid), 32'(0));
    force_step = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'(0));
    check({name, "_res_valid"}, 32'(bus.res_valid), 32'(0));
    check({name, "_res_data"}, 32'(bus.res_data), 32'(0));
    check({name, "_res_err"}, 32'(bus.res_err), 32'(0));
    check({name, "_sh_en"}, 32'(sh_en), 32'(0));
    check({name, "_sh_fun"}, 32'(sh_fun), 32'(0));
    check({name, "_sh_ab"}, {sh_a, sh_b}, 32'(0));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'(0));
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 32'(bus.req_ready), 32'(1));

    run_req("a_left4",   2'b01, 16'h0001, 5'd4,  0, 0, 16'h0010, 9,     1'b0);
    run_req("b_right15", 2'b10, 16'h8000, 5'd15, 0, 0, 16'h0001, 31,    1'b0);
    run_req("amt0",      2'b00, 16'hBEEF, 5'd0,  0, 0, 16'hBEEF, 1,     1'b0);
    run_req("amt20",     2'b01, 16'hFFFF, 5'd20, 0, 0, 16'h0000, LAT20, 1'b0);
    run_req("hold5",     2'b00, 16'h00F0, 5'd3,  5, 0, 16'h001E, 7,     1'b0);

    // Reset pulse landing in the WAIT phase of a 6-step request.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_data  = 16'h0003;
    bus.req_amt   = 5'd6;
    @(negedge clk);
    check("rst6_accepted", 32'(bus.req_ready), 32'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_rst");
    check("after_rst_req_ready", 32'(bus.req_ready), 32'(1));

    run_req("b_left1",   2'b11, 16'h1234, 5'd1,  0, 0, 16'h2468, 3,     1'b0);
    run_req("err_step2", 2'b01, 16'h0001, 5'd3,  0, 2, 16'h0008, 7,     1'b1);
    run_req("clean",     2'b10, 16'h00FF, 5'd2,  0, 0, 16'h003F, 5,     1'b0);
    run_req("amt31",     2'b00, 16'hFFFF, 5'd31, 0, 0, 16'h0000, LAT31, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that sequences the single-step registered shift unit to perform multi-position shifts. It accepts a shift request over a valid/ready handshake and drives the shift unit's enable, function and operand inputs once per step. It captures each registered step result and feeds it back until the requested amount is reached, then presents the final value on a valid/ready result port. It sits between the ALU command decoder and the shift unit.

## Interface
- DATA_WIDTH, 16, operand/result width; must equal the shift unit's IN_DATA_WIDTH
- AMT_WIDTH, 5, width of shift amount; amounts up to 2^AMT_WIDTH-1 accepted
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  2  bit0 direction (0 right, 1 left); bit1 port select (0 drive A, 1 drive B)
- req_data  in  DATA_WIDTH  value to shift
- req_amt  in  AMT_WIDTH  number of 1-bit steps
- res_valid  out  1  result present
- res_ready  in  1  consumer takes result
- res_data  out  DATA_WIDTH  shifted value
- res_err  out  1  a step returned without shift flag
- busy  out  1  state != IDLE
- sh_en  out  1  to shift unit Shift_EN
- sh_fun  out  2  to shift unit ALU_FUN = {req_op[1], req_op[0]}
- sh_a, sh_b  out  DATA_WIDTH  shift unit operands; unselected port driven 0
- sh_out  in  DATA_WIDTH  shift unit registered output
- sh_flag  in  1  shift unit registered flag

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid: latch op, data into work register, amount into down-counter.
  - If amount = 0, go to DONE with res_data = req_data.
  - Otherwise go to ISSUE.
- ISSUE: sh_en=1, sh_fun=op, selected port = work register. Go to WAIT.
- WAIT: sh_en=0.
  - Load the work register from sh_out and decrement the counter.
  - If sh_flag=0, set the err latch.
  - If the counter reaches 0, go to DONE; otherwise go to ISSUE.
- DONE: res_valid=1. res_data and res_err are held stable.
  - On res_ready, go to IDLE and clear the err latch.
  - The next request is accepted no earlier than the following cycle.
- Shifts are logical; vacated bits are filled with 0.
- The counter is AMT_WIDTH wide and never wraps: decrement happens only in WAIT with counter > 0.
- rst in any state: next state IDLE, all outputs 0, in-flight operation discarded. The shift unit is reset by its own reset.

## Timing
- Reset values: req_ready=0 while rst is high and 1 after; res_valid=0, res_data=0, res_err=0, busy=0, sh_en=0, sh_fun=0, sh_a=0, sh_b=0.
- Accept cycle = c0. For amount k ≥ 1, res_valid rises in cycle c(2k+1). Each step costs 2 cycles because the shift unit registers its output.
- Amount 0: res_valid in c1; sh_en never asserted.
- sh_en is a single-cycle pulse per step, never high in two consecutive cycles.
- res_valid is held until res_ready. req_ready=0 from c1 until the cycle after the result handshake.

## Configuration
- SHIFT_SEQ_FASTPATH_EN defined:
  - A request with amount ≥ DATA_WIDTH skips iteration and goes directly to DONE with res_data=0.
  - res_valid in c1; no sh_en pulses.
- SHIFT_SEQ_FASTPATH_EN undefined:
  - Such requests iterate the full amount through the shift unit.
  - Result is 0; res_valid in c(2k+1).

## Structure
- Package shift_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE)
  - op bit-position constants (OP_DIR_BIT=0, OP_PORT_BIT=1)
  - the shift-function encodings (A right 00, A left 01, B right 10, B left 11)
- One sub-module, shift_amount_counter: loadable AMT_WIDTH down-counter with load, dec and zero outputs.
- The FSM, work register and shift-unit drive live in shift_sequencer. The testbench instantiates shift_sequencer together with the existing shift unit.

## Test plan
- DATA_WIDTH=16, op=01, data=0x0001, amt=4 -> res_data=0x0010, res_valid in c9, exactly 4 sh_en pulses on port A.
- op=10, data=0x8000, amt=15 -> res_data=0x0001, res_valid in c31, sh_a=0 throughout, sh_b carries the operand.
- amt=0, data=0xBEEF -> res_data=0xBEEF in c1, no sh_en pulses; amt=20 -> 0x0000 in c1 with SHIFT_SEQ_FASTPATH_EN, in c41 without.
- res_ready held low 5 cycles after res_valid -> res_data, res_err and res_valid stable; req_ready=0; req_valid ignored until the handshake completes.
- rst pulsed for 1 cycle during WAIT of a 6-step request -> next cycle IDLE, all outputs 0; a new request afterwards completes correctly.
- Bench forces sh_flag=0 on the second step of a 3-step request -> res_err=1 with the result; err cleared after the handshake; the next clean request returns res_err=0.
